// File: rtl/alu_div_seq_if.sv
// Handshake and operand/result bundle for the sequential divider.
// master = control unit issuing divides, slave = alu_div_seq.
interface alu_div_seq_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             signed_op;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   modport master (
      output start, signed_op, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, signed_op, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/alu_div_seq.sv
// Multi-cycle restoring divider, one quotient bit per clock, start/busy/done handshake.
// Define ALU_DIV_SIGNED_EN to honour signed_op (two's-complement, truncating).
module alu_div_seq #(
   parameter  int WIDTH = 32,
   localparam int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic        clk,
   input  logic        clr,
   alu_div_seq_if.slave bus
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state, state_nx;
   logic               accept;
   logic [WIDTH:0]     acc;
   logic [WIDTH-1:0]   q;
   logic [WIDTH-1:0]   m;
   logic [CNT_W-1:0]   cnt;
   logic               zero_op;
   logic               finish;
   logic [WIDTH-1:0]   quo_r;
   logic [WIDTH-1:0]   rem_r;
   logic               dbz_r;
   logic [WIDTH:0]     shifted;
   logic [WIDTH:0]     diff;
   logic [WIDTH-1:0]   abs_n;
   logic [WIDTH-1:0]   abs_d;
   logic [WIDTH-1:0]   q_fin;
   logic [WIDTH-1:0]   r_fin;

`ifdef ALU_DIV_SIGNED_EN
   logic sgn_n, sgn_d;
   logic neg_q, neg_r;

   always_comb begin
      sgn_n = bus.signed_op & bus.dividend[WIDTH-1];
      sgn_d = bus.signed_op & bus.divisor[WIDTH-1];
      abs_n = sgn_n ? -bus.dividend : bus.dividend;
      abs_d = sgn_d ? -bus.divisor  : bus.divisor;
      q_fin = neg_q ? -q : q;
      r_fin = neg_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         neg_q <= 1'b0;
         neg_r <= 1'b0;
      end else if (accept) begin
         neg_q <= sgn_n ^ sgn_d;
         neg_r <= sgn_n;
      end
   end
`else
   always_comb begin
      abs_n = bus.dividend;
      abs_d = bus.divisor;
      q_fin = q;
      r_fin = acc[WIDTH-1:0];
   end
`endif

   always_comb begin
      shifted = {acc[WIDTH-1:0], q[WIDTH-1]};
      diff    = shifted - {1'b0, m};
      finish  = (state == RUN) && (zero_op || (cnt == CNT_W'(WIDTH)));
      accept  = bus.start && ((state == IDLE) || (state == DONE));
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) state <= IDLE;
      else     state <= state_nx;
   end

   // A zero divisor still spends the one cycle after acceptance in RUN, so done
   // appears on the edge after the accepting edge with busy covering that cycle.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept) state_nx = RUN;
         RUN:     if (finish) state_nx = DONE;
         DONE:    state_nx = accept ? RUN : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         acc     <= '0;
         q       <= '0;
         m       <= '0;
         cnt     <= '0;
         zero_op <= 1'b0;
         quo_r   <= '0;
         rem_r   <= '0;
         dbz_r   <= 1'b0;
      end else if (accept) begin
         zero_op <= (bus.divisor == '0);
         // On divide-by-zero q keeps the raw dividend for the remainder result.
         q       <= (bus.divisor == '0) ? bus.dividend : abs_n;
         m       <= abs_d;
         acc     <= '0;
         cnt     <= '0;
      end else if (finish) begin
         dbz_r <= zero_op;
         if (zero_op) begin
            quo_r <= '1;
            rem_r <= q;
         end else begin
            quo_r <= q_fin;
            rem_r <= r_fin;
         end
      end else if (state == RUN) begin
         if (!diff[WIDTH]) begin
            acc <= diff;
            q   <= {q[WIDTH-2:0], 1'b1};
         end else begin
            acc <= shifted;
            q   <= {q[WIDTH-2:0], 1'b0};
         end
         cnt <= cnt + 1'b1;
      end
   end

   assign bus.busy        = (state == RUN);
   assign bus.done        = (state == DONE);
   assign bus.quotient    = quo_r;
   assign bus.remainder   = rem_r;
   assign bus.div_by_zero = dbz_r;

endmodule

// File: tb/tb_alu_div_seq.sv
// Directed self-checking bench for alu_div_seq (WIDTH=32); signed cases build
// only when ALU_DIV_SIGNED_EN is defined, otherwise the unsigned reading is checked.
module tb_alu_div_seq;
   localparam int W = 32;

   logic clk = 1'b0;
   logic clr = 1'b1;
   int   checks = 0;
   int   errors = 0;

   alu_div_seq_if #(.WIDTH(W)) bus ();

   alu_div_seq #(.WIDTH(W)) dut (
      .clk (clk),
      .clr (clr),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Issue one operation and wait for done; lat counts edges from the accepting
   // edge to the edge that raised done (-1 on timeout), bcnt counts busy samples.
   task automatic run_op(input logic [W-1:0] dd, input logic [W-1:0] dv,
                         input logic sop, output int lat, output int bcnt);
      @(negedge clk);
      bus.start = 1'b1; bus.dividend = dd; bus.divisor = dv; bus.signed_op = sop;
      @(posedge clk); #1;
      bus.start = 1'b0;
      lat = -1; bcnt = 0;
      for (int i = 1; i <= 100; i++) begin
         if (bus.busy) bcnt++;
         @(posedge clk); #1;
         if (bus.done) begin lat = i; break; end
      end
   endtask

   task automatic test_reset();
      #1;
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
      checks++; if (bus.quotient !== 32'd0) begin errors++; $display("FAIL reset_quot: got %h want 0", bus.quotient); end
      checks++; if (bus.remainder !== 32'd0) begin errors++; $display("FAIL reset_rem: got %h want 0", bus.remainder); end
      checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz: got %b want 0", bus.div_by_zero); end
      @(negedge clk); clr = 1'b0;
   endtask

   task automatic test_unsigned();
      int lat, bc;
      run_op(32'd100, 32'd7, 1'b0, lat, bc);
      checks++; if (lat !== 33) begin errors++; $display("FAIL u100_7_latency: got %0d want 33", lat); end
      checks++; if (bc !== 33) begin errors++; $display("FAIL u100_7_busy_cycles: got %0d want 33", bc); end
      checks++; if (bus.quotient !== 32'd14) begin errors++; $display("FAIL u100_7_quot: got %0d want 14", bus.quotient); end
      checks++; if (bus.remainder !== 32'd2) begin errors++; $display("FAIL u100_7_rem: got %0d want 2", bus.remainder); end
      checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL u100_7_dbz: got %b want 0", bus.div_by_zero); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL u100_7_busy_at_done: got %b want 0", bus.busy); end
      @(posedge clk); #1;
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL done_one_cycle: got %b want 0", bus.done); end
      checks++; if (bus.quotient !== 32'd14) begin errors++; $display("FAIL quot_held: got %0d want 14", bus.quotient); end

      run_op(32'hFFFF_FFFF, 32'h8000_0000, 1'b0, lat, bc);
      checks++; if (bus.quotient !== 32'd1) begin errors++; $display("FAIL ufff_8000_quot: got %h want 1", bus.quotient); end
      checks++; if (bus.remainder !== 32'h7FFF_FFFF) begin errors++; $display("FAIL ufff_8000_rem: got %h want 7fffffff", bus.remainder); end

      run_op(32'd5, 32'hFFFF_FFFF, 1'b0, lat, bc);
      checks++; if (bus.quotient !== 32'd0) begin errors++; $display("FAIL u5_fff_quot: got %h want 0", bus.quotient); end
      checks++; if (bus.remainder !== 32'd5) begin errors++; $display("FAIL u5_fff_rem: got %h want 5", bus.remainder); end
   endtask

   task automatic test_signed();
      int lat, bc;
`ifdef ALU_DIV_SIGNED_EN
      run_op(-32'sd7, 32'd2, 1'b1, lat, bc);
      checks++; if (bus.quotient !== 32'hFFFF_FFFD) begin errors++; $display("FAIL s_m7_2_quot: got %h want fffffffd", bus.quotient); end
      checks++; if (bus.remainder !== 32'hFFFF_FFFF) begin errors++; $display("FAIL s_m7_2_rem: got %h want ffffffff", bus.remainder); end
      run_op(32'd7, -32'sd2, 1'b1, lat, bc);
      checks++; if (bus.quotient !== 32'hFFFF_FFFD) begin errors++; $display("FAIL s_7_m2_quot: got %h want fffffffd", bus.quotient); end
      checks++; if (bus.remainder !== 32'd1) begin errors++; $display("FAIL s_7_m2_rem: got %h want 1", bus.remainder); end
      run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, lat, bc);
      checks++; if (bus.quotient !== 32'h8000_0000) begin errors++; $display("FAIL s_min_m1_quot: got %h want 80000000", bus.quotient); end
      checks++; if (bus.remainder !== 32'd0) begin errors++; $display("FAIL s_min_m1_rem: got %h want 0", bus.remainder); end
      checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL s_min_m1_dbz: got %b want 0", bus.div_by_zero); end
      run_op(32'd100, 32'd7, 1'b1, lat, bc);
      checks++; if (bus.quotient !== 32'd14) begin errors++; $display("FAIL s_100_7_quot: got %h want e", bus.quotient); end
`else
      run_op(-32'sd7, 32'd2, 1'b1, lat, bc);
      checks++; if (bus.quotient !== 32'h7FFF_FFFC) begin errors++; $display("FAIL nosign_m7_2_quot: got %h want 7ffffffc", bus.quotient); end
      checks++; if (bus.remainder !== 32'd1) begin errors++; $display("FAIL nosign_m7_2_rem: got %h want 1", bus.remainder); end
      run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, lat, bc);
      checks++; if (bus.quotient !== 32'd0) begin errors++; $display("FAIL nosign_min_m1_quot: got %h want 0", bus.quotient); end
      checks++; if (bus.remainder !== 32'h8000_0000) begin errors++; $display("FAIL nosign_min_m1_rem: got %h want 80000000", bus.remainder); end
`endif
   endtask

   task automatic test_div_zero();
      int lat, bc;
      run_op(32'd1234, 32'd0, 1'b0, lat, bc);
      checks++; if (lat !== 1) begin errors++; $display("FAIL dbz_latency: got %0d want 1", lat); end
      checks++; if (bus.quotient !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dbz_quot: got %h want ffffffff", bus.quotient); end
      checks++; if (bus.remainder !== 32'd1234) begin errors++; $display("FAIL dbz_rem: got %0d want 1234", bus.remainder); end
      checks++; if (bus.div_by_zero !== 1'b1) begin errors++; $display("FAIL dbz_flag: got %b want 1", bus.div_by_zero); end
      @(negedge clk); bus.start = 1'b1; bus.dividend = 32'd10; bus.divisor = 32'd3;
      @(posedge clk); #1; bus.start = 1'b0;
      checks++; if (bus.div_by_zero !== 1'b1) begin errors++; $display("FAIL dbz_held_in_flight: got %b want 1", bus.div_by_zero); end
      for (int i = 0; i < 100 && !bus.done; i++) begin @(posedge clk); #1; end
      checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL dbz_cleared: got %b want 0", bus.div_by_zero); end
      checks++; if (bus.quotient !== 32'd3) begin errors++; $display("FAIL after_dbz_quot: got %0d want 3", bus.quotient); end
      checks++; if (bus.remainder !== 32'd1) begin errors++; $display("FAIL after_dbz_rem: got %0d want 1", bus.remainder); end
   endtask

   task automatic test_ignore_restart();
      int lat;
      @(negedge clk);
      bus.start = 1'b1; bus.dividend = 32'd100; bus.divisor = 32'd7; bus.signed_op = 1'b0;
      @(posedge clk); #1; bus.start = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      bus.start = 1'b1; bus.dividend = 32'd50; bus.divisor = 32'd5;
      @(negedge clk); bus.start = 1'b0;
      lat = -1;
      for (int i = 7; i <= 100; i++) begin
         @(posedge clk); #1;
         if (bus.done) begin lat = i; break; end
      end
      checks++; if (lat !== 33) begin errors++; $display("FAIL restart_latency: got %0d want 33", lat); end
      checks++; if (bus.quotient !== 32'd14) begin errors++; $display("FAIL restart_quot: got %0d want 14", bus.quotient); end
      checks++; if (bus.remainder !== 32'd2) begin errors++; $display("FAIL restart_rem: got %0d want 2", bus.remainder); end
   endtask

   task automatic test_back_to_back();
      int lat;
      @(negedge clk);
      bus.start = 1'b1; bus.dividend = 32'd100; bus.divisor = 32'd7; bus.signed_op = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < 100 && !bus.done; i++) begin @(posedge clk); #1; end
      checks++; if (bus.quotient !== 32'd14) begin errors++; $display("FAIL b2b_first_quot: got %0d want 14", bus.quotient); end
      // still in the DONE cycle with start held high: present the next operands
      bus.dividend = 32'd10; bus.divisor = 32'd3;
      @(posedge clk); #1;
      bus.start = 1'b0;
      checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: got done=%b busy=%b want done=0 busy=1", bus.done, bus.busy); end
      lat = -1;
      for (int i = 1; i <= 100; i++) begin
         @(posedge clk); #1;
         if (bus.done) begin lat = i; break; end
      end
      checks++; if (lat !== 33) begin errors++; $display("FAIL b2b_latency: got %0d want 33", lat); end
      checks++; if (bus.quotient !== 32'd3) begin errors++; $display("FAIL b2b_second_quot: got %0d want 3", bus.quotient); end
      checks++; if (bus.remainder !== 32'd1) begin errors++; $display("FAIL b2b_second_rem: got %0d want 1", bus.remainder); end
   endtask

   task automatic test_reset_mid();
      int lat, bc;
      bit seen;
      @(negedge clk);
      bus.start = 1'b1; bus.dividend = 32'd100; bus.divisor = 32'd7; bus.signed_op = 1'b0;
      @(posedge clk); #1; bus.start = 1'b0;
      repeat (9) @(posedge clk);
      #2 clr = 1'b1;
      #1;
      checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL midreset_ctrl: got busy=%b done=%b want 0 0", bus.busy, bus.done); end
      checks++; if (bus.quotient !== 32'd0 || bus.remainder !== 32'd0) begin errors++; $display("FAIL midreset_data: got q=%h r=%h want 0 0", bus.quotient, bus.remainder); end
      @(negedge clk); clr = 1'b0;
      seen = 1'b0;
      repeat (40) begin @(posedge clk); #1; if (bus.done || bus.busy) seen = 1'b1; end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midreset_no_done: got activity=%b want 0", seen); end
      run_op(32'd100, 32'd7, 1'b0, lat, bc);
      checks++; if (lat !== 33 || bus.quotient !== 32'd14 || bus.remainder !== 32'd2) begin
         errors++; $display("FAIL post_reset_op: got lat=%0d q=%0d r=%0d want 33 14 2", lat, bus.quotient, bus.remainder);
      end
   endtask

   initial begin
      bus.start = 1'b0; bus.signed_op = 1'b0; bus.dividend = '0; bus.divisor = '0;
      test_reset();
      test_unsigned();
      test_signed();
      test_div_zero();
      test_ignore_restart();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
